// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin arbiter that shares one bank of NREG registers
// between requester 0 (core) and requester 1 (debug/DMA). Each transaction
// runs IDLE -> ACCESS -> RESP: a one-cycle strobe in ACCESS, then a done pulse
// (and err for out-of-range addresses) in RESP.
// Optional feature macro: RBA_WRITEU_EN enables upper-byte writes (reg_writeu).
module reg_bus_arbiter #(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0,
    input  logic            req1,
    input  logic            we0,
    input  logic            we1,
    input  logic            wu0,
    input  logic            wu1,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [DW-1:0]   wdata0,
    input  logic [DW-1:0]   wdata1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            done0,
    output logic            done1,
    output logic            err,
    output logic [DW-1:0]   rdata,
    output logic [DW-1:0]   reg_din,
    input  logic [DW-1:0]   reg_dout,
    output logic [NREG-1:0] reg_read,
    output logic [NREG-1:0] reg_write,
    output logic [NREG-1:0] reg_writeu
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q;
    logic            sel_valid, sel_owner;
    logic [AW-1:0]   addr_q;
    logic            we_q;
    logic [DW-1:0]   rdata_q;
    logic [DW-1:0]   reg_din_q;
    logic            gnt0_q, gnt1_q, done0_q, done1_q, err_q;
    logic            gnt0_d, gnt1_d, done0_d, done1_d, err_d;
    logic            addr_ok;

`ifdef RBA_WRITEU_EN
    logic            wu_q;
`else
    // wu has no effect without the upper-write feature
    logic            unused_wu;
    assign unused_wu = ^{wu0, wu1};
`endif

    assign addr_ok = 32'(addr_q) < NREG;

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign reg_din = reg_din_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration and next-state: requests are only looked at in IDLE
    always_comb begin
        sel_valid = req0 | req1;
        sel_owner = 1'b0;
        if (req0 && req1) begin
            sel_owner = ~last_q;
        end else if (req1) begin
            sel_owner = 1'b1;
        end
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: next values for registered handshakes, live strobes
    always_comb begin
        owner_d = owner_q;
        if (state_q == IDLE && sel_valid) begin
            owner_d = sel_owner;
        end
        gnt0_d  = (state_d != IDLE) && !owner_d;
        gnt1_d  = (state_d != IDLE) && owner_d;
        done0_d = (state_d == RESP) && !owner_q;
        done1_d = (state_d == RESP) && owner_q;
        err_d   = (state_d == RESP) && !addr_ok;

        reg_read   = '0;
        reg_write  = '0;
        reg_writeu = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (state_q == ACCESS && addr_ok && 32'(addr_q) == i) begin
                if (!we_q) begin
                    reg_read[i] = 1'b1;
                end else begin
`ifdef RBA_WRITEU_EN
                    if (wu_q) reg_writeu[i] = 1'b1;
                    else      reg_write[i]  = 1'b1;
`else
                    reg_write[i] = 1'b1;
`endif
                end
            end
        end
    end

    // Transaction latch, read capture and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            addr_q    <= '0;
            we_q      <= 1'b0;
`ifdef RBA_WRITEU_EN
            wu_q      <= 1'b0;
`endif
            reg_din_q <= '0;
            rdata_q   <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            owner_q <= owner_d;
            if (state_q == IDLE && sel_valid) begin
                last_q    <= sel_owner;
                addr_q    <= sel_owner ? addr1 : addr0;
                we_q      <= sel_owner ? we1 : we0;
`ifdef RBA_WRITEU_EN
                wu_q      <= sel_owner ? wu1 : wu0;
`endif
                reg_din_q <= sel_owner ? wdata1 : wdata0;
            end
            if (state_q == ACCESS) begin
                if (!addr_ok) begin
                    rdata_q <= '0;
                end else if (!we_q) begin
                    rdata_q <= reg_dout;
                end
            end
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed testbench for reg_bus_arbiter: an 8-register instance with a
// modelled bank, and a 6-register instance (fixed read data) sharing the same
// requester inputs for the out-of-range case.
module tb_reg_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, wu0, wu1;
    logic [2:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;

    logic        gnt0, gnt1, done0, done1, err;
    logic [15:0] rdata, reg_din, reg_dout;
    logic [7:0]  reg_read, reg_write, reg_writeu;

    logic        gnt0_6, gnt1_6, done0_6, done1_6, err_6;
    logic [15:0] rdata_6, reg_din_6;
    logic [15:0] reg_dout_6 = 16'hDEAD;
    logic [5:0]  reg_read_6, reg_write_6, reg_writeu_6;

    logic [15:0] bank [8];
    logic        bank_clr;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    reg_bus_arbiter #(.NREG(8), .AW(3), .DW(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .wu0(wu0), .wu1(wu1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
        .rdata(rdata), .reg_din(reg_din), .reg_dout(reg_dout),
        .reg_read(reg_read), .reg_write(reg_write), .reg_writeu(reg_writeu)
    );

    reg_bus_arbiter #(.NREG(6), .AW(3), .DW(16)) u_dut6 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .wu0(wu0), .wu1(wu1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_6), .gnt1(gnt1_6), .done0(done0_6), .done1(done1_6), .err(err_6),
        .rdata(rdata_6), .reg_din(reg_din_6), .reg_dout(reg_dout_6),
        .reg_read(reg_read_6), .reg_write(reg_write_6), .reg_writeu(reg_writeu_6)
    );

    // Register bank model: full write, upper-byte write, combinational read
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (bank_clr)          bank[i] <= 16'h0000;
            else if (reg_write[i]) bank[i] <= reg_din;
            else if (reg_writeu[i]) bank[i][15:8] <= reg_din[15:8];
        end
    end

    always_comb begin
        reg_dout = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (reg_read[i]) reg_dout = bank[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; bank_clr = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; wu0 = 0; wu1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        tick(); tick();
        check("rst_hs", {27'd0, gnt0, gnt1, done0, done1, err}, 32'h0);
        check("rst_rdata", {16'd0, rdata}, 32'h0);
        check("rst_din", {16'd0, reg_din}, 32'h0);
        check("rst_strobe", {8'd0, reg_read, reg_write, reg_writeu}, 32'h0);
        rst_n = 1'b1; bank_clr = 1'b0;
        tick();

        // Write 0F0F to reg 2 from requester 0, then read it back
        req0 = 1; we0 = 1; addr0 = 3'd2; wdata0 = 16'h0F0F;
        tick();
        check("wr_strobe", {24'd0, reg_write}, 32'h04);
        check("wr_other", {16'd0, reg_read, reg_writeu}, 32'h0);
        check("wr_gnt", {29'd0, gnt0, gnt1, done0}, 32'b100);
        check("wr_din", {16'd0, reg_din}, 32'h0F0F);
        tick();
        check("wr_resp", {29'd0, gnt0, done0, |reg_write}, 32'b110);
        req0 = 0;
        tick();
        check("wr_idle", {30'd0, gnt0, done0}, 32'h0);
        check("wr_bank", {16'd0, bank[2]}, 32'h0F0F);
        req0 = 1; we0 = 0;
        tick();
        check("rd_strobe", {24'd0, reg_read}, 32'h04);
        tick();
        check("rd_done", {31'd0, done0}, 32'h1);
        check("rd_data", {16'd0, rdata}, 32'h0F0F);
        req0 = 0;
        tick();

        // Requester 1 write with wu set to reg 5
        req1 = 1; we1 = 1; wu1 = 1; addr1 = 3'd5; wdata1 = 16'h0003;
        tick();
`ifdef RBA_WRITEU_EN
        check("wu_strobe", {16'd0, reg_writeu, reg_write}, {16'd0, 8'h20, 8'h00});
`else
        check("wu_strobe", {16'd0, reg_writeu, reg_write}, {16'd0, 8'h00, 8'h20});
`endif
        check("wu_gnt", {30'd0, gnt0, gnt1}, 32'b01);
        tick();
        check("wu_done", {30'd0, done0, done1}, 32'b01);
        req1 = 0; we1 = 0; wu1 = 0;
        tick();

        // Reset in the middle of an ACCESS cycle of a write
        req0 = 1; we0 = 1; addr0 = 3'd3; wdata0 = 16'h1234;
        tick();
        check("ab_strobe", {24'd0, reg_write}, 32'h08);
        rst_n = 1'b0;
        #1;
        check("ab_strb0", {8'd0, reg_read, reg_write, reg_writeu}, 32'h0);
        check("ab_hs", {28'd0, gnt0, gnt1, done0, done1}, 32'h0);
        check("ab_rdata", {16'd0, rdata}, 32'h0);
        // Set up both requesters for the fairness run while still in reset
        req0 = 1; we0 = 0; addr0 = 3'd0; req1 = 1; we1 = 0; addr1 = 3'd1;
        tick();
        check("ab_nodone", {30'd0, done0, done1}, 32'h0);
        check("ab_bank", {16'd0, bank[3]}, 32'h0);
        rst_n = 1'b1;

        // Both requesting continuously: owners 0,1,0,1, one transaction per 3 cycles
        for (int k = 1; k <= 12; k++) begin
            int ph, own;
            logic [3:0] exp_hs;
            tick();
            ph  = (k - 1) % 3;
            own = ((k - 1) / 3) % 2;
            exp_hs = {(ph < 2) && (own == 0), (ph < 2) && (own == 1),
                      (ph == 1) && (own == 0), (ph == 1) && (own == 1)};
            check($sformatf("rr_k%0d", k), {28'd0, gnt0, gnt1, done0, done1}, {28'd0, exp_hs});
        end
        req0 = 0; req1 = 0;
        tick();

        // Out-of-range read on the 6-register instance
        req0 = 1; we0 = 0; addr0 = 3'd7;
        tick();
        check("oob_strobe", {14'd0, reg_read_6, reg_write_6, reg_writeu_6}, 32'h0);
        check("oob_in8", {24'd0, reg_read}, 32'h80);
        tick();
        check("oob_resp", {30'd0, done0_6, err_6}, 32'b11);
        check("oob_rdata", {16'd0, rdata_6}, 32'h0);
        check("oob_err8", {31'd0, err}, 32'h0);
        req0 = 0;
        tick();

        // Requester 1 holds req past done; requester 0 joins and wins next
        req1 = 1; we1 = 0; addr1 = 3'd1;
        tick();
        check("hold_gnt1", {30'd0, gnt0, gnt1}, 32'b01);
        tick();
        check("hold_done1", {30'd0, done0, done1}, 32'b01);
        tick();
        check("hold_idle", {28'd0, gnt0, gnt1, done0, done1}, 32'h0);
        tick();
        check("hold_gnt2", {30'd0, gnt0, gnt1}, 32'b01);
        req0 = 1; we0 = 0; addr0 = 3'd0;
        tick();
        check("hold_done2", {30'd0, done0, done1}, 32'b01);
        tick();
        tick();
        check("hold_win0", {30'd0, gnt0, gnt1}, 32'b10);
        req1 = 0;
        tick();
        check("hold_done0", {30'd0, done0, done1}, 32'b10);
        req0 = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
